// File: rtl/risc_ctrl_fsm_if.sv
// Memory handshake bundle between the control FSM (master) and instruction/data memory (slave).
// The FSM drives request, command and address source; memory answers with mem_ready.
interface risc_ctrl_fsm_if;
    logic       mem_req;
    logic [1:0] mem_cmd;
    logic       addr_sel;
    logic       mem_ready;

    modport master (
        output mem_req,
        output mem_cmd,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_cmd,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/risc_ctrl_fsm.sv
// Control FSM for the Simple RISC Machine: fetch, PC update, decode, execute, writeback,
// plus LDR/STR memory handshake, HALT, illegal-opcode trap and memory-wait timeout.
module risc_ctrl_fsm #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            opcode,
    input  logic [1:0]            op,
    risc_ctrl_fsm_if.master       mem,
    output logic                  loada,
    output logic                  loadb,
    output logic                  loadc,
    output logic                  loads,
    output logic                  asel,
    output logic                  bsel,
    output logic [1:0]            vsel,
    output logic [2:0]            nsel,
    output logic                  write,
    output logic                  load_ir,
    output logic                  load_pc,
    output logic                  reset_pc,
    output logic                  load_addr,
    output logic                  halted,
    output logic                  err,
    output logic [1:0]            err_code
);

    typedef enum logic [4:0] {
        StResetPc,
        StFetch,
        StLoadIr,
        StUpdatePc,
        StDecode,
        StMovImm,
        StMovrB,
        StMovrC,
        StGetA,
        StGetB,
        StAlu,
        StAluCmp,
        StWbRd,
        StLdaA,
        StLdaC,
        StLdaLd,
        StMemRd,
        StLdrWb,
        StStrB,
        StStrC,
        StMemWr,
        StHalt,
        StError
    } state_e;

    localparam logic [CNT_W-1:0] LastWait = CNT_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             in_wait;
    logic             timed_out;

    assign in_wait   = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
    // mem_ready takes priority: a timeout only fires on a cycle where memory is still busy.
    assign timed_out = (TIMEOUT != 0) && in_wait && !mem.mem_ready && (wait_cnt_q == LastWait);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StResetPc;
            wait_cnt_q <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_code_q <= err_code_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        err_code_d = err_code_q;
        case (state_q)
            StResetPc:  state_d = StFetch;
            StFetch: begin
                if (mem.mem_ready) begin
                    state_d = StLoadIr;
                end else if (timed_out) begin
                    state_d    = StError;
                    err_code_d = 2'b10;
                end
            end
            StLoadIr:   state_d = StUpdatePc;
            StUpdatePc: state_d = StDecode;
            StDecode: begin
                if (opcode == 3'b110 && op == 2'b10) begin
                    state_d = StMovImm;
                end else if (opcode == 3'b110 && op == 2'b00) begin
                    state_d = StMovrB;
                end else if (opcode == 3'b101) begin
                    state_d = StGetA;
                end else if ((opcode == 3'b011 || opcode == 3'b100) && op == 2'b00) begin
                    state_d = StLdaA;
                end else if (opcode == 3'b111) begin
                    state_d = StHalt;
                end else begin
                    state_d    = StError;
                    err_code_d = 2'b01;
                end
            end
            StMovImm:   state_d = StFetch;
            StMovrB:    state_d = StMovrC;
            StMovrC:    state_d = StWbRd;
            StGetA:     state_d = StGetB;
            // CMP gets its own ALU state so the status load stays a pure state decode.
            StGetB:     state_d = (op == 2'b01) ? StAluCmp : StAlu;
            StAlu:      state_d = StWbRd;
            StAluCmp:   state_d = StFetch;
            StWbRd:     state_d = StFetch;
            StLdaA:     state_d = StLdaC;
            StLdaC:     state_d = StLdaLd;
            StLdaLd:    state_d = (opcode == 3'b011) ? StMemRd : StStrB;
            StMemRd: begin
                if (mem.mem_ready) begin
                    state_d = StLdrWb;
                end else if (timed_out) begin
                    state_d    = StError;
                    err_code_d = 2'b10;
                end
            end
            StLdrWb:    state_d = StFetch;
            StStrB:     state_d = StStrC;
            StStrC:     state_d = StMemWr;
            StMemWr: begin
                if (mem.mem_ready) begin
                    state_d = StFetch;
                end else if (timed_out) begin
                    state_d    = StError;
                    err_code_d = 2'b10;
                end
            end
            StHalt:     state_d = StHalt;
            StError:    state_d = StError;
            default:    state_d = StResetPc;
        endcase
    end

    // Staying in a wait state means memory was not ready; any other transition is a fresh entry.
    assign wait_cnt_d = (in_wait && state_d == state_q) ? wait_cnt_q + CNT_W'(1) : '0;

    always_comb begin
        loada         = 1'b0;
        loadb         = 1'b0;
        loadc         = 1'b0;
        loads         = 1'b0;
        asel          = 1'b0;
        bsel          = 1'b0;
        vsel          = 2'b00;
        nsel          = 3'b000;
        write         = 1'b0;
        load_ir       = 1'b0;
        load_pc       = 1'b0;
        reset_pc      = 1'b0;
        load_addr     = 1'b0;
        halted        = 1'b0;
        err           = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_cmd   = 2'b00;
        mem.addr_sel  = 1'b0;
        case (state_q)
            StResetPc: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
            end
            StFetch: begin
                mem.mem_req  = 1'b1;
                mem.mem_cmd  = 2'b01;
                mem.addr_sel = 1'b1;
            end
            StLoadIr: begin
                load_ir      = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_cmd  = 2'b01;
            end
            StUpdatePc: load_pc = 1'b1;
            StMovImm: begin
                nsel  = 3'b100;
                vsel  = 2'b10;
                write = 1'b1;
            end
            StMovrB, StGetB: begin
                nsel  = 3'b001;
                loadb = 1'b1;
            end
            StMovrC, StStrC: begin
                asel  = 1'b1;
                loadc = 1'b1;
            end
            StGetA, StLdaA: begin
                nsel  = 3'b100;
                loada = 1'b1;
            end
            StAlu:    loadc = 1'b1;
            StAluCmp: loads = 1'b1;
            StWbRd: begin
                nsel  = 3'b010;
                vsel  = 2'b00;
                write = 1'b1;
            end
            StLdaC: begin
                bsel  = 1'b1;
                loadc = 1'b1;
            end
            StLdaLd: load_addr = 1'b1;
            StMemRd: begin
                mem.mem_req = 1'b1;
                mem.mem_cmd = 2'b01;
            end
            StLdrWb: begin
                nsel        = 3'b010;
                vsel        = 2'b01;
                mem.mem_cmd = 2'b01;
                write       = 1'b1;
            end
            StStrB: begin
                nsel  = 3'b010;
                loadb = 1'b1;
            end
            StMemWr: begin
                mem.mem_req = 1'b1;
                mem.mem_cmd = 2'b10;
            end
            StHalt:  halted = 1'b1;
            StError: err    = 1'b1;
            default: ;
        endcase
    end

    assign err_code = err_code_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Bench for risc_ctrl_fsm: an instruction-level model expands each instruction into its expected
// per-cycle output trace; every cycle is compared, plus literal pins from the test plan.
module tb_risc_ctrl_fsm;

    localparam int unsigned TO = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] opcode = 3'b000;
    logic [1:0] op = 2'b00;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] vsel;
    logic [2:0] nsel;
    logic       write, load_ir, load_pc, reset_pc, load_addr, halted, err;
    logic [1:0] err_code;

    risc_ctrl_fsm_if mif ();

    risc_ctrl_fsm #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .mem       (mif),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .vsel      (vsel),
        .nsel      (nsel),
        .write     (write),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .load_addr (load_addr),
        .halted    (halted),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] vsel;
        logic [2:0] nsel;
        logic       write, load_ir, load_pc, reset_pc, load_addr, addr_sel, mem_req;
        logic [1:0] mem_cmd;
        logic       halted, err;
        logic [1:0] err_code;
    } outs_t;

    typedef struct packed {
        logic       rdy;
        logic [2:0] opc;
        logic [1:0] op;
        outs_t      exp;
    } entry_t;

    entry_t     q[$];
    outs_t      trace[$];
    logic [2:0] cur_opc;
    logic [1:0] cur_op;
    int         n_chk = 0;
    int         n_err = 0;

    initial mif.mem_ready = 1'b0;

    function automatic outs_t sample();
        outs_t o;
        o = '{loada: loada, loadb: loadb, loadc: loadc, loads: loads, asel: asel, bsel: bsel,
              vsel: vsel, nsel: nsel, write: write, load_ir: load_ir, load_pc: load_pc,
              reset_pc: reset_pc, load_addr: load_addr, addr_sel: mif.addr_sel,
              mem_req: mif.mem_req, mem_cmd: mif.mem_cmd, halted: halted, err: err,
              err_code: err_code};
        return o;
    endfunction

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- instruction-level model ----------------
    task automatic push(input logic rdy, input outs_t o);
        entry_t e;
        e.rdy = rdy;
        e.opc = cur_opc;
        e.op  = cur_op;
        e.exp = o;
        q.push_back(e);
    endtask

    // Outside wait states mem_ready is don't-care, so it toggles to prove it is ignored.
    task automatic pushp(input outs_t o);
        push(logic'(q.size() % 2), o);
    endtask

    task automatic push_err(input logic [1:0] code);
        outs_t o = '0;
        o.err      = 1'b1;
        o.err_code = code;
        repeat (6) pushp(o);
    endtask

    // A memory wait of w busy cycles, then ready; past the timeout it becomes an error.
    task automatic push_wait(input outs_t o, input int w, output bit dead);
        if (TO > 0 && w >= int'(TO)) begin
            repeat (TO) push(1'b0, o);
            push_err(2'b10);
            dead = 1'b1;
        end else begin
            repeat (w) push(1'b0, o);
            push(1'b1, o);
            dead = 1'b0;
        end
    endtask

    function automatic outs_t o_fetch();
        outs_t o = '0;
        o.mem_req  = 1'b1;
        o.mem_cmd  = 2'b01;
        o.addr_sel = 1'b1;
        return o;
    endfunction

    task automatic run_instr(input logic [2:0] opc, input logic [1:0] opv, input int fw,
                             input int mw);
        outs_t o;
        bit    dead;
        cur_opc = opc;
        cur_op  = opv;
        push_wait(o_fetch(), fw, dead);
        if (dead) return;
        o = '0; o.load_ir = 1'b1; o.addr_sel = 1'b1; o.mem_cmd = 2'b01; pushp(o);
        o = '0; o.load_pc = 1'b1; pushp(o);
        o = '0; pushp(o);
        if (opc == 3'b110 && opv == 2'b10) begin
            o = '0; o.nsel = 3'b100; o.vsel = 2'b10; o.write = 1'b1; pushp(o);
        end else if ((opc == 3'b110 && opv == 2'b00) || opc == 3'b101) begin
            if (opc == 3'b110) begin
                o = '0; o.nsel = 3'b001; o.loadb = 1'b1; pushp(o);
                o = '0; o.asel = 1'b1; o.loadc = 1'b1; pushp(o);
            end else begin
                o = '0; o.nsel = 3'b100; o.loada = 1'b1; pushp(o);
                o = '0; o.nsel = 3'b001; o.loadb = 1'b1; pushp(o);
                o = '0;
                if (opv == 2'b01) o.loads = 1'b1; else o.loadc = 1'b1;
                pushp(o);
            end
            if (!(opc == 3'b101 && opv == 2'b01)) begin
                o = '0; o.nsel = 3'b010; o.write = 1'b1; pushp(o);
            end
        end else if ((opc == 3'b011 || opc == 3'b100) && opv == 2'b00) begin
            o = '0; o.nsel = 3'b100; o.loada = 1'b1; pushp(o);
            o = '0; o.bsel = 1'b1; o.loadc = 1'b1; pushp(o);
            o = '0; o.load_addr = 1'b1; pushp(o);
            if (opc == 3'b011) begin
                o = '0; o.mem_req = 1'b1; o.mem_cmd = 2'b01;
                push_wait(o, mw, dead);
                if (dead) return;
                o = '0; o.nsel = 3'b010; o.vsel = 2'b01; o.mem_cmd = 2'b01; o.write = 1'b1;
                pushp(o);
            end else begin
                o = '0; o.nsel = 3'b010; o.loadb = 1'b1; pushp(o);
                o = '0; o.asel = 1'b1; o.loadc = 1'b1; pushp(o);
                o = '0; o.mem_req = 1'b1; o.mem_cmd = 2'b10;
                push_wait(o, mw, dead);
            end
        end else if (opc == 3'b111) begin
            o = '0; o.halted = 1'b1;
            repeat (20) pushp(o);
        end else begin
            push_err(2'b01);
        end
    endtask

    task automatic push_tail();
        push(1'b0, o_fetch());
    endtask

    // ---------------- drive + compare ----------------
    task automatic drain(input int n);
        entry_t e;
        outs_t  act;
        for (int i = 0; i < n && q.size() > 0; i++) begin
            e = q.pop_front();
            @(negedge clk);
            opcode        = e.opc;
            op            = e.op;
            mif.mem_ready = e.rdy;
            act = sample();
            trace.push_back(act);
            chk($sformatf("cycle%0d", trace.size() - 1), act, e.exp);
        end
    endtask

    task automatic do_reset();
        outs_t r = '0;
        r.reset_pc = 1'b1;
        r.load_pc  = 1'b1;
        q.delete();
        trace.delete();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", sample(), r);
        reset = 1'b0;
        trace.push_back(sample());
    endtask

    initial begin
        int         acc;
        logic [2:0] ill_opc[5] = '{3'b000, 3'b110, 3'b011, 3'b100, 3'b001};
        logic [1:0] ill_op[5]  = '{2'b00, 2'b01, 2'b01, 2'b11, 2'b10};

        // MOV #imm, ADD, CMP, MOV reg back to back
        do_reset();
        run_instr(3'b110, 2'b10, 0, 0);
        run_instr(3'b101, 2'b00, 0, 0);
        run_instr(3'b101, 2'b01, 0, 0);
        run_instr(3'b110, 2'b00, 0, 0);
        push_tail();
        drain(q.size());
        chk("mov_wr_c6", 24'({trace[5].write, trace[5].nsel, trace[5].vsel}), 24'(6'b1_100_10));
        chk("mov_fetch_c7", 24'({trace[6].mem_req, trace[6].mem_cmd}), 24'(3'b1_01));
        chk("add_wb", 24'({trace[13].write, trace[13].nsel}), 24'(4'b1_010));
        chk("cmp_loads", 24'(trace[20].loads), 24'(1));
        acc = 0;
        for (int i = 14; i <= 20; i++) acc += int'(trace[i].write);
        chk("cmp_no_write", 24'(acc), 24'(0));
        chk("movr_fetch", 24'(trace[28].mem_req), 24'(1));

        // LDR with 3 busy cycles, then STR with memory always ready
        do_reset();
        run_instr(3'b011, 2'b00, 0, 3);
        run_instr(3'b100, 2'b00, 0, 0);
        push_tail();
        drain(q.size());
        for (int i = 8; i <= 11; i++)
            chk($sformatf("ldr_hold%0d", i),
                24'({trace[i].mem_req, trace[i].addr_sel, trace[i].mem_cmd}), 24'(4'b1_0_01));
        chk("ldr_wb", 24'({trace[12].vsel, trace[12].nsel, trace[12].write}), 24'(6'b01_010_1));
        chk("str_addr", 24'(trace[19].load_addr), 24'(1));
        chk("str_b", 24'({trace[20].loadb, trace[20].nsel}), 24'(4'b1_010));
        chk("str_c", 24'({trace[21].asel, trace[21].loadc}), 24'(2'b11));
        chk("str_wr", 24'({trace[22].mem_req, trace[22].mem_cmd}), 24'(3'b1_10));
        chk("str_fetch", 24'({trace[23].mem_req, trace[23].mem_cmd}), 24'(3'b1_01));

        // Ready on the last allowed FETCH cycle wins over the timeout
        do_reset();
        run_instr(3'b110, 2'b10, TO - 1, 0);
        push_tail();
        drain(q.size());
        chk("late_ready", 24'({trace[17].load_ir, trace[17].err}), 24'(2'b10));

        // FETCH timeout
        do_reset();
        run_instr(3'b110, 2'b10, TO, 0);
        drain(q.size());
        chk("fetch_timeout",
            24'({trace[17].err, trace[17].err_code, trace[17].mem_req}), 24'(4'b1_10_0));

        // MEM_RD and MEM_WR timeouts
        do_reset();
        run_instr(3'b011, 2'b00, 0, TO);
        drain(q.size());
        do_reset();
        run_instr(3'b100, 2'b00, 0, TO + 3);
        drain(q.size());

        // Illegal encodings
        for (int k = 0; k < 5; k++) begin
            do_reset();
            run_instr(ill_opc[k], ill_op[k], 0, 0);
            drain(q.size());
            chk($sformatf("illegal%0d", k), 24'({trace[5].err, trace[5].err_code}), 24'(3'b1_01));
        end

        // HALT stays put
        do_reset();
        run_instr(3'b111, 2'b10, 0, 0);
        drain(q.size());
        acc = 0;
        for (int i = 5; i <= 24; i++) acc += int'(halted === 1'b1 ? trace[i].halted : trace[i].halted);
        chk("halt_20", 24'(acc), 24'(20));

        // Asynchronous reset while MEM_WR is waiting
        do_reset();
        run_instr(3'b100, 2'b00, 0, 10);
        drain(12);
        chk("mid_wr_busy", 24'({mif.mem_req, mif.mem_cmd}), 24'(3'b1_10));
        #2 reset = 1'b1;
        #1;
        chk("mid_wr_reset",
            24'({reset_pc, mif.mem_req, err_code}), 24'(4'b1_0_00));

        // Clean restart after the mid-operation reset
        do_reset();
        run_instr(3'b110, 2'b10, 2, 0);
        push_tail();
        drain(q.size());

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
